pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DW, default 96: payload data width (operands, ALU output, instruction).
REQ-002 SHALL provide parameter CW, default 8: control-bit width (read/write enables, mem-to-reg, write select, flags).
REQ-003 SHALL provide parameter SKID, default 1: 1 = two-entry skid buffer, 0 = single register, no skid.
REQ-004 SHALL provide parameter HALT_BIT, default 2: index in ctrl of the halt flag.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 CLK  input  1  rising-edge clock.
REQ-007 RST  input  1  asynchronous active-high reset.
REQ-008 flush  input  1  synchronous squash of all held beats.
REQ-009 in_valid  input  1  upstream beat present.
REQ-010 in_ready  output  1  stage accepts a beat this cycle.
REQ-011 in_ctrl  input  CW  upstream control bits.
REQ-012 in_data  input  DW  upstream payload.
REQ-013 out_valid  output  1  downstream beat present.
REQ-014 out_ready  input  1  downstream consumes the beat this cycle.
REQ-015 out_ctrl  output  CW  held control bits; zero whenever out_valid=0.
REQ-016 out_data  output  DW  held payload.
REQ-017 occupancy  output  2  beats held: 0, 1 or 2.
REQ-018 halted  output  1  sticky: halt beat has left the stage.

Function
REQ-019 Accept = in_valid & in_ready; transfer = out_valid & out_ready; both evaluated at the same rising edge.
REQ-020 SKID=1 states: EMPTY (occ 0), FULL (main valid, occ 1), SKID (main+skid valid, occ 2).
REQ-021 SKID=1: in_ready = (state != SKID) & ~halted & ~flush; no combinational path from out_ready.
REQ-022 EMPTY: accept -> FULL, main <= input; otherwise stay in EMPTY.
REQ-023 FULL: accept & transfer -> FULL, main <= input; accept only -> SKID, skid <= input; transfer only -> EMPTY; neither -> hold.
REQ-024 SKID: transfer -> FULL, main <= skid; no transfer -> hold; no accept possible.
REQ-025 Output order SHALL equal input order; a held beat SHALL NOT change until transferred or flushed.
REQ-026 SKID=0: in_ready = (~out_valid | out_ready) & ~halted & ~flush; states EMPTY/FULL only; occupancy never 2.
REQ-027 Latency: an accepted beat appears on out_* the cycle after acceptance; throughput is 1 beat/cycle with out_ready held high.
REQ-028 flush: next state EMPTY, main/skid ctrl cleared to 0, data registers retained (don't-care); flush overrides same-cycle accept and transfer.
REQ-029 A transfer with out_ctrl[HALT_BIT]=1 SHALL set halted at that edge.
REQ-030 When halted=1: in_ready=0, out_valid=0, out_ctrl=0; state forced to EMPTY; only RST clears halted; flush does not clear halted.
REQ-031 A halt beat still held in the stage SHALL be discarded by flush without setting halted.
REQ-032 Beats accepted behind a halt beat (in skid) SHALL be discarded when halted sets.

Reset
REQ-033 While RST=1: state EMPTY, occupancy 0, out_valid 0, in_ready 0, out_ctrl 0, out_data 0, halted 0, regardless of CLK.
REQ-034 First rising edge after RST deasserts: in_ready=1 (if flush=0); RST mid-operation drops all held beats immediately.

Verification
REQ-035 Stream: out_ready=1, 4 beats data 0x11..0x44 back-to-back -> out_data 0x11..0x44 on consecutive cycles, occupancy stays 1, in_ready=1 throughout.
REQ-036 Backpressure (SKID=1): out_ready=0, send 0xA1, 0xA2, 0xA3 -> occ 1 then 2, in_ready=0 after 0xA2, 0xA3 held upstream; out_ready=1 -> 0xA1, 0xA2, 0xA3 in order.
REQ-037 Flush at occ 2 with in_valid=1 -> next cycle occupancy 0, out_valid 0, out_ctrl 0, input beat not accepted.
REQ-038 Halt: beat ctrl=0x04 followed by 0x55 at out_ready=0, then out_ready=1 -> halted=1 after 0x04 transfers, 0x55 never appears, in_ready stays 0 until RST.
REQ-039 Async reset: RST pulsed mid-cycle at occ 2 -> out_valid=0 and occupancy 0 before next CLK edge.
REQ-040 SKID=0 build: out_ready=0 at occ 1 -> in_ready=0; out_ready=1 same cycle with in_valid=1 -> pass-through, occupancy stays 1.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake, payload and status bundle for one pipeline stage register
interface pipe_stage_reg_if #(
    parameter int DW = 96,
    parameter int CW = 8
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic          halted;

    // Upstream/downstream environment side: drives beats in, consumes beats out
    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy, halted
    );

    // Stage side
    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy, halted
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with optional two-entry skid buffer, flush and sticky halt
module pipe_stage_reg #(
    parameter int DW       = 96,
    parameter int CW       = 8,
    parameter int SKID     = 1,
    parameter int HALT_BIT = 2
) (
    input logic            clk,
    input logic            rst,
    pipe_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } stateT;

    stateT         stateQ;
    stateT         stateD;
    logic [CW-1:0] mainCtrl;
    logic [DW-1:0] mainData;
    logic [CW-1:0] skidCtrl;
    logic [DW-1:0] skidData;
    logic          haltedQ;

    logic          inReady;
    logic          outValid;
    logic [1:0]    occ;
    logic          acceptBeat;
    logic          transferBeat;
    logic          haltNow;

    // A halt beat only counts once it really leaves; a same-cycle flush squashes it instead
    assign acceptBeat   = bus.in_valid & inReady;
    assign transferBeat = outValid & bus.out_ready;
    assign haltNow      = transferBeat & mainCtrl[HALT_BIT] & ~bus.flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= S_EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state: flush and halt both empty the stage and win over any handshake
    always_comb begin
        stateD = stateQ;
        if (bus.flush || haltedQ || haltNow) begin
            stateD = S_EMPTY;
        end else begin
            case (stateQ)
                S_EMPTY: begin
                    if (acceptBeat) stateD = S_FULL;
                end
                S_FULL: begin
                    if (acceptBeat && !transferBeat) stateD = S_SKID;
                    else if (!acceptBeat && transferBeat) stateD = S_EMPTY;
                end
                S_SKID: begin
                    if (transferBeat) stateD = S_FULL;
                end
                default: stateD = S_EMPTY;
            endcase
        end
    end

    // Outputs: skid build keeps in_ready independent of out_ready; reset holds it low
    always_comb begin
        outValid = (stateQ != S_EMPTY) && !haltedQ;
        if (SKID != 0) begin
            inReady = (stateQ != S_SKID) && !haltedQ && !bus.flush && !rst;
        end else begin
            inReady = (!outValid || bus.out_ready) && !haltedQ && !bus.flush && !rst;
        end
        case (stateQ)
            S_FULL:  occ = 2'd1;
            S_SKID:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    // Beat storage: main always feeds the output, skid catches the beat that arrives while main stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainCtrl <= '0;
            mainData <= '0;
            skidCtrl <= '0;
            skidData <= '0;
        end else if (bus.flush || haltNow) begin
            mainCtrl <= '0;
            skidCtrl <= '0;
        end else begin
            case (stateQ)
                S_EMPTY: begin
                    if (acceptBeat) begin
                        mainCtrl <= bus.in_ctrl;
                        mainData <= bus.in_data;
                    end
                end
                S_FULL: begin
                    if (acceptBeat && transferBeat) begin
                        mainCtrl <= bus.in_ctrl;
                        mainData <= bus.in_data;
                    end else if (acceptBeat) begin
                        skidCtrl <= bus.in_ctrl;
                        skidData <= bus.in_data;
                    end
                end
                S_SKID: begin
                    if (transferBeat) begin
                        mainCtrl <= skidCtrl;
                        mainData <= skidData;
                    end
                end
                default: begin
                    mainCtrl <= '0;
                    skidCtrl <= '0;
                end
            endcase
        end
    end

    // Sticky halt: set when the halt beat leaves, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haltedQ <= 1'b0;
        end else if (haltNow) begin
            haltedQ <= 1'b1;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_ctrl  = outValid ? mainCtrl : '0;
    assign bus.out_data  = mainData;
    assign bus.occupancy = occ;
    assign bus.halted    = haltedQ;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, skid and no-skid builds
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [95:0] data;
    } beatT;

    beatT sb[$];
    logic haltedExp;

    pipe_stage_reg_if #(.DW(96), .CW(8)) busA ();
    pipe_stage_reg_if #(.DW(96), .CW(8)) busB ();

    pipe_stage_reg #(.DW(96), .CW(8), .SKID(1), .HALT_BIT(2)) dutA (
        .clk(clk),
        .rst(rst),
        .bus(busA.slave)
    );

    pipe_stage_reg #(.DW(96), .CW(8), .SKID(0), .HALT_BIT(2)) dutB (
        .clk(clk),
        .rst(rst),
        .bus(busB.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveA(input logic v, input logic [7:0] c, input logic [95:0] d);
        busA.in_valid = v;
        busA.in_ctrl  = c;
        busA.in_data  = d;
    endtask

    // Called just after a falling edge with inputs set; checks the model, then advances one clock
    task automatic cycleA();
        beatT exp;
        logic expValid;
        logic expReady;
        logic acc;
        logic xfer;
        #1;
        expValid = (sb.size() != 0);
        expReady = (sb.size() < 2) && !haltedExp && !busA.flush;
        check("occupancy", 128'(busA.occupancy), 128'(sb.size()));
        check("out_valid", 128'(busA.out_valid), 128'(expValid));
        check("in_ready", 128'(busA.in_ready), 128'(expReady));
        check("halted", 128'(busA.halted), 128'(haltedExp));
        if (!expValid) check("out_ctrl_idle", 128'(busA.out_ctrl), 128'(0));
        acc  = busA.in_valid && expReady;
        xfer = expValid && busA.out_ready;
        if (busA.flush) begin
            sb.delete();
        end else begin
            if (xfer) begin
                exp = sb.pop_front();
                check("out_data", 128'(busA.out_data), 128'(exp.data));
                check("out_ctrl", 128'(busA.out_ctrl), 128'(exp.ctrl));
                if (exp.ctrl[2]) begin
                    haltedExp = 1'b1;
                    sb.delete();
                    acc = 1'b0;
                end
            end
            if (acc) sb.push_back({busA.in_ctrl, busA.in_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        haltedExp = 1'b0;
        busA.flush = 1'b0; busA.out_ready = 1'b0; driveA(1'b0, 8'h0, 96'h0);
        busB.flush = 1'b0; busB.out_ready = 1'b0;
        busB.in_valid = 1'b0; busB.in_ctrl = 8'h0; busB.in_data = 96'h0;

        // Reset state while RST is held
        #3;
        check("rst_occupancy", 128'(busA.occupancy), 128'(0));
        check("rst_out_valid", 128'(busA.out_valid), 128'(0));
        check("rst_in_ready", 128'(busA.in_ready), 128'(0));
        check("rst_out_ctrl", 128'(busA.out_ctrl), 128'(0));
        check("rst_out_data", 128'(busA.out_data), 128'(0));
        check("rst_halted", 128'(busA.halted), 128'(0));
        check("rst_in_ready_b", 128'(busB.in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back stream with out_ready high
        busA.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            driveA(1'b1, 8'h00, 96'(8'h11 * i));
            cycleA();
        end
        driveA(1'b0, 8'h0, 96'h0);
        cycleA();
        cycleA();

        // Backpressure fills main then skid; third beat waits upstream
        busA.out_ready = 1'b0;
        driveA(1'b1, 8'h01, 96'hA1); cycleA();
        driveA(1'b1, 8'h02, 96'hA2); cycleA();
        driveA(1'b1, 8'h03, 96'hA3); cycleA();
        cycleA();
        busA.out_ready = 1'b1;
        cycleA();
        cycleA();
        driveA(1'b0, 8'h0, 96'h0);
        cycleA();
        cycleA();

        // Flush at occupancy 2 with a beat offered
        busA.out_ready = 1'b0;
        driveA(1'b1, 8'h81, 96'hB1); cycleA();
        driveA(1'b1, 8'h82, 96'hB2); cycleA();
        driveA(1'b1, 8'h83, 96'hB3);
        busA.flush = 1'b1;
        cycleA();
        busA.flush = 1'b0;
        driveA(1'b0, 8'h0, 96'h0);
        cycleA();
        busA.out_ready = 1'b1;
        cycleA();

        // Halt beat squashed by flush does not set halted
        busA.out_ready = 1'b0;
        driveA(1'b1, 8'h04, 96'hC4); cycleA();
        driveA(1'b0, 8'h0, 96'h0);
        busA.out_ready = 1'b1;
        busA.flush = 1'b1;
        cycleA();
        busA.flush = 1'b0;
        cycleA();

        // Asynchronous reset mid-cycle at occupancy 2
        busA.out_ready = 1'b0;
        driveA(1'b1, 8'h11, 96'hD1); cycleA();
        driveA(1'b1, 8'h12, 96'hD2); cycleA();
        driveA(1'b0, 8'h0, 96'h0);
        #1;
        check("pre_async_occ", 128'(busA.occupancy), 128'(2));
        #1;
        rst = 1'b1;
        #1;
        check("async_occupancy", 128'(busA.occupancy), 128'(0));
        check("async_out_valid", 128'(busA.out_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        cycleA();

        // Halt beat followed by a beat in skid; the second must never appear
        driveA(1'b1, 8'h04, 96'h99); cycleA();
        driveA(1'b1, 8'h00, 96'h55); cycleA();
        driveA(1'b0, 8'h0, 96'h0);
        busA.out_ready = 1'b1;
        cycleA();
        driveA(1'b1, 8'h00, 96'h66);
        for (int i = 0; i < 4; i++) cycleA();
        busA.flush = 1'b1;
        cycleA();
        busA.flush = 1'b0;
        cycleA();

        // Only reset clears halted
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        haltedExp = 1'b0;
        driveA(1'b0, 8'h0, 96'h0);
        cycleA();

        // No-skid build: stall then pass-through
        busB.out_ready = 1'b0;
        busB.in_valid = 1'b1; busB.in_ctrl = 8'h21; busB.in_data = 96'hE1;
        #1;
        check("b_ready_empty", 128'(busB.in_ready), 128'(1));
        @(posedge clk); @(negedge clk);
        #1;
        check("b_occ_stall", 128'(busB.occupancy), 128'(1));
        check("b_ready_stall", 128'(busB.in_ready), 128'(0));
        check("b_data_stall", 128'(busB.out_data), 128'(96'hE1));
        @(posedge clk); @(negedge clk);
        busB.out_ready = 1'b1;
        busB.in_ctrl = 8'h22; busB.in_data = 96'hE2;
        #1;
        check("b_ready_pass", 128'(busB.in_ready), 128'(1));
        check("b_ctrl_pass", 128'(busB.out_ctrl), 128'(8'h21));
        @(posedge clk); @(negedge clk);
        busB.in_valid = 1'b0;
        #1;
        check("b_occ_pass", 128'(busB.occupancy), 128'(1));
        check("b_data_pass", 128'(busB.out_data), 128'(96'hE2));
        @(posedge clk); @(negedge clk);
        #1;
        check("b_occ_drain", 128'(busB.occupancy), 128'(0));
        check("b_out_valid_drain", 128'(busB.out_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
